fetch_unit: RTL

Parametrised instruction-fetch stage that succeeds the single-cycle PC/next-PC logic for the pipelined datapath. Holds the PC, issues instruction-memory reads through the datapath–cache interface signals, predicts next-PC with a direct-mapped branch target buffer (BTB) of 2-bit counters, and registers fetched instructions into the IF/ID boundary. Accepts stall, mispredict redirect and halt from later stages. Sits between the cache's instruction port and the decode stage.

---
 rtl/fetch_unit_pkg.sv | 53 +++++
 rtl/fetch_unit_if.sv | 51 +++++
 rtl/fetch_unit_btb.sv | 71 +++++++
 rtl/fetch_unit.sv | 100 ++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction-fetch stage:
// BTB entry layout, counter encodings, IF/ID bundle.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } cnt_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] tag;
        logic [31:0] target;
        cnt_t        cnt;
    } btb_entry_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] npc;
        logic        pred_taken;
        logic [31:0] pred_target;
    } fetch_out_t;

    typedef enum logic {
        FS_RUN  = 1'b0,
        FS_HALT = 1'b1
    } fstate_t;

    function automatic cnt_t cnt_inc(cnt_t c);
        cnt_t r;
        unique case (c)
            STRONG_NT: r = WEAK_NT;
            WEAK_NT:   r = WEAK_T;
            default:   r = STRONG_T;
        endcase
        return r;
    endfunction

    function automatic cnt_t cnt_dec(cnt_t c);
        cnt_t r;
        unique case (c)
            STRONG_T: r = WEAK_T;
            WEAK_T:   r = WEAK_NT;
            default:  r = STRONG_NT;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Datapath/cache <-> fetch stage signal bundle.
// fu = fetch side, dp = datapath side, tb = bench driver.
interface fetch_unit_if;

    logic        ihit;
    logic [31:0] imemload;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        stall;
    logic        mispredict;
    logic [31:0] correct_pc;
    logic        resolve_valid;
    logic [31:0] resolve_pc;
    logic        resolve_taken;
    logic [31:0] resolve_target;
    logic        halt;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_npc;
    logic        if_pred_taken;
    logic [31:0] if_pred_target;

    modport fu (
        input  ihit, imemload, stall, mispredict, correct_pc,
        input  resolve_valid, resolve_pc, resolve_taken,
        input  resolve_target, halt,
        output imemREN, imemaddr,
        output if_valid, if_instr, if_pc, if_npc,
        output if_pred_taken, if_pred_target
    );

    modport dp (
        output ihit, imemload, stall, mispredict, correct_pc,
        output resolve_valid, resolve_pc, resolve_taken,
        output resolve_target, halt,
        input  imemREN, imemaddr,
        input  if_valid, if_instr, if_pc, if_npc,
        input  if_pred_taken, if_pred_target
    );

    modport tb (
        output ihit, imemload, stall, mispredict, correct_pc,
        output resolve_valid, resolve_pc, resolve_taken,
        output resolve_target, halt,
        input  imemREN, imemaddr,
        input  if_valid, if_instr, if_pc, if_npc,
        input  if_pred_taken, if_pred_target
    );

endinterface

// File: rtl/fetch_unit_btb.sv
// Direct-mapped branch target buffer with 2-bit counters.
// Lookup is combinational; updates land at the clock edge.
module branch_target_buffer
    import fetch_unit_pkg::*;
#(
    parameter int BTB_ENTRIES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] lookup_pc_i,
    output logic        hit_o,
    output logic        pred_taken_o,
    output logic [31:0] target_o,
    input  logic        resolve_valid_i,
    input  logic [31:0] resolve_pc_i,
    input  logic        resolve_taken_i,
    input  logic [31:0] resolve_target_i
);

    localparam int IDX = $clog2(BTB_ENTRIES);

    btb_entry_t mem_q [BTB_ENTRIES];

    logic [IDX-1:0] lidx;
    logic [31:0]    ltag;
    btb_entry_t     lent;
    logic [IDX-1:0] uidx;
    logic [31:0]    utag;
    logic           uhit;

    // Lookup on the current PC; sees pre-update contents
    always_comb begin
        lidx         = IDX'(lookup_pc_i >> 2);
        ltag         = lookup_pc_i >> (IDX + 2);
        lent         = mem_q[lidx];
        hit_o        = lent.valid && (lent.tag == ltag);
        pred_taken_o = hit_o && lent.cnt[1];
        target_o     = lent.target;
    end

    // Index/tag match for the resolving instruction
    always_comb begin
        uidx = IDX'(resolve_pc_i >> 2);
        utag = resolve_pc_i >> (IDX + 2);
        uhit = mem_q[uidx].valid && (mem_q[uidx].tag == utag);
    end

    // Train counters on hit, allocate on taken miss
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                mem_q[i] <= '0;
            end
        end else if (resolve_valid_i) begin
            if (uhit) begin
                if (resolve_taken_i) begin
                    mem_q[uidx].cnt    <= cnt_inc(mem_q[uidx].cnt);
                    mem_q[uidx].target <= resolve_target_i;
                end else begin
                    mem_q[uidx].cnt <= cnt_dec(mem_q[uidx].cnt);
                end
            end else if (resolve_taken_i) begin
                mem_q[uidx].valid  <= 1'b1;
                mem_q[uidx].tag    <= utag;
                mem_q[uidx].target <= resolve_target_i;
                mem_q[uidx].cnt    <= WEAK_T;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, BTB-based next-PC
// prediction and the IF/ID pipeline register.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] PC_INIT     = 32'h0,
    parameter int          BTB_ENTRIES = 16
) (
    input  logic    CLK,
    input  logic    RST,
    fetch_unit_if.fu bus
);

    logic [31:0] pc_q, pc_d;
    fstate_t     st_q, st_d;
    fetch_out_t  out_q, out_d;

    logic        btb_hit;
    logic        btb_taken;
    logic [31:0] btb_target;
    logic        pred_taken;
    logic [31:0] pc_plus4;
    logic [31:0] pred_next;

    branch_target_buffer #(
        .BTB_ENTRIES(BTB_ENTRIES)
    ) u_btb (
        .clk_i           (CLK),
        .rst_i           (RST),
        .lookup_pc_i     (pc_q),
        .hit_o           (btb_hit),
        .pred_taken_o    (btb_taken),
        .target_o        (btb_target),
        .resolve_valid_i (bus.resolve_valid),
        .resolve_pc_i    (bus.resolve_pc),
        .resolve_taken_i (bus.resolve_taken),
        .resolve_target_i(bus.resolve_target)
    );

    // Next-PC prediction for the address being fetched
    always_comb begin
        pc_plus4   = pc_q + 32'd4;
        pred_taken = btb_hit && btb_taken;
        pred_next  = pred_taken ? btb_target : pc_plus4;
    end

    // Redirect > halt > stall > fetch > bubble
    always_comb begin
        pc_d  = pc_q;
        st_d  = st_q;
        out_d = out_q;
        if (bus.mispredict) begin
            pc_d        = bus.correct_pc;
            out_d.valid = 1'b0;
        end else if (st_q == FS_HALT || bus.halt) begin
            st_d = FS_HALT;
            if (!bus.stall) begin
                out_d.valid = 1'b0;
            end
        end else if (bus.stall) begin
            pc_d = pc_q;
        end else if (bus.ihit) begin
            out_d.valid       = 1'b1;
            out_d.instr       = bus.imemload;
            out_d.pc          = pc_q;
            out_d.npc         = pc_plus4;
            out_d.pred_taken  = pred_taken;
            out_d.pred_target = pred_next;
            pc_d              = pred_next;
        end else begin
            out_d.valid = 1'b0;
        end
    end

    // PC, halt state and IF/ID register
    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_q  <= PC_INIT;
            st_q  <= FS_RUN;
            out_q <= '0;
        end else begin
            pc_q  <= pc_d;
            st_q  <= st_d;
            out_q <= out_d;
        end
    end

    // Memory request and IF/ID outputs
    always_comb begin
        bus.imemREN        = (st_q != FS_HALT);
        bus.imemaddr       = pc_q;
        bus.if_valid       = out_q.valid;
        bus.if_instr       = out_q.instr;
        bus.if_pc          = out_q.pc;
        bus.if_npc         = out_q.npc;
        bus.if_pred_taken  = out_q.pred_taken;
        bus.if_pred_target = out_q.pred_target;
    end

endmodule
